// File: rtl/delay_cal_pkg.sv
// delay_cal_pkg -- shared definitions for the delay-line calibration block.
//   DELAY_CODE_W / DELAY_CODE_MAX : width and top value of the delay code
//   cal_state_e                   : calibration FSM state encoding
//   lock_code()                   : maps the best passing code to the code
//                                   that is finally driven on delay_sel
// Optional feature macro: DELAY_CAL_MARGIN_EN (lock one code below the best
// passing code, saturating at 0).
package delay_cal_pkg;

  localparam int DELAY_CODE_W = 4;
  localparam logic [DELAY_CODE_W-1:0] DELAY_CODE_MAX = 4'd15;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    LAUNCH  = 3'd2,
    CAPTURE = 3'd3,
    EVAL    = 3'd4,
    DONE    = 3'd5,
    FAIL    = 3'd6
  } cal_state_e;

  function automatic logic [DELAY_CODE_W-1:0] lock_code(input logic [DELAY_CODE_W-1:0] best);
`ifdef DELAY_CAL_MARGIN_EN
    // Back off one code from the edge of the passing window for margin.
    return (best == '0) ? '0 : best - 1'b1;
`else
    return best;
`endif
  endfunction

endpackage

// File: rtl/delay_cal_sampler.sv
// delay_cal_sampler -- probe launch/capture datapath of the delay calibrator.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : zero the hit and sample counters
//   launch     : toggle probe_out on this edge
//   capture    : compare probe_in with probe_out and count on this edge
//   probe_in   : delay line output
//   probe_out  : toggling test signal into the delay line
//   hit_cnt    : captures where probe_in matched probe_out
//   sample_cnt : captures taken in the current trial
module delay_cal_sampler #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             launch,
  input  logic             capture,
  input  logic             probe_in,
  output logic             probe_out,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] sample_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      probe_out  <= 1'b0;
      hit_cnt    <= '0;
      sample_cnt <= '0;
    end else begin
      if (launch) begin
        probe_out <= ~probe_out;
      end
      if (clear) begin
        hit_cnt    <= '0;
        sample_cnt <= '0;
      end else if (capture) begin
        sample_cnt <= sample_cnt + 1'b1;
        // A match means the toggle launched one cycle earlier made it
        // through the delay line within a single clock period.
        if (probe_in == probe_out) begin
          hit_cnt <= hit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/delay_cal_ctrl.sv
// delay_cal_ctrl -- sweeps the delay code upward from 0, probing each code
// SAMPLES times, and locks the last code at which every probe got through
// the delay line within one clock period.
//   SETTLE_CYC : cycles to wait after each delay_sel change before probing
//   SAMPLES    : probe launches per trial code (1..255)
//   clk, rst   : clock, synchronous active-high reset
//   cal_start  : one-cycle start request
//   probe_out  : test signal into the delay line
//   probe_in   : delay line output
//   delay_sel  : delay code to the delay line
//   cal_busy   : calibration in progress
//   cal_done   : level, calibration succeeded
//   cal_fail   : level, code 0 already failed
//   dbg_state  : current FSM state
// Optional feature macro: DELAY_CAL_MARGIN_EN (see delay_cal_pkg::lock_code).
//
// Start handshake: cal_start is a request with an implicit ready that is high
// only in IDLE, DONE and FAIL; a pulse is accepted on an edge where both are
// high and is silently dropped otherwise. cal_busy rises on the accepting edge.
module delay_cal_ctrl
  import delay_cal_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLES    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cal_start,
  output logic                    probe_out,
  input  logic                    probe_in,
  output logic [DELAY_CODE_W-1:0] delay_sel,
  output logic                    cal_busy,
  output logic                    cal_done,
  output logic                    cal_fail,
  output cal_state_e              dbg_state
);

  // One spare count so SAMPLES itself is representable and never wraps.
  localparam int CNT_W = $clog2(SAMPLES + 1);
  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SAMPLES_C   = CNT_W'(SAMPLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

  cal_state_e              state;
  logic [DELAY_CODE_W-1:0] code;
  logic [DELAY_CODE_W-1:0] best;
  logic [SET_W-1:0]        settle_cnt;
  logic [CNT_W-1:0]        hit_cnt;
  logic [CNT_W-1:0]        sample_cnt;
  logic                    start_ok;
  logic                    last_sample;
  logic                    trial_pass;

  assign start_ok    = cal_start && ((state == IDLE) || (state == DONE) || (state == FAIL));
  // Evaluated in CAPTURE, before this capture is counted.
  assign last_sample = (sample_cnt == SAMPLES_C - 1'b1);
  assign trial_pass  = (hit_cnt == SAMPLES_C);
  assign dbg_state   = state;

  delay_cal_sampler #(
    .CNT_W (CNT_W)
  ) u_sampler (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok || (state == EVAL)),
    .launch     (state == LAUNCH),
    .capture    (state == CAPTURE),
    .probe_in   (probe_in),
    .probe_out  (probe_out),
    .hit_cnt    (hit_cnt),
    .sample_cnt (sample_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      code       <= '0;
      best       <= '0;
      settle_cnt <= '0;
      delay_sel  <= '0;
      cal_busy   <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start_ok) begin
            state      <= SETTLE;
            code       <= '0;
            best       <= '0;
            settle_cnt <= '0;
            delay_sel  <= '0;
            cal_busy   <= 1'b1;
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
          end else if (state == DONE) begin
            delay_sel <= lock_code(best);
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= LAUNCH;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        LAUNCH: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state <= last_sample ? EVAL : LAUNCH;
        end
        EVAL: begin
          if (trial_pass && (code != DELAY_CODE_MAX)) begin
            best      <= code;
            code      <= code + 1'b1;
            delay_sel <= code + 1'b1;
            state     <= SETTLE;
          end else if (trial_pass) begin
            best      <= DELAY_CODE_MAX;
            delay_sel <= lock_code(DELAY_CODE_MAX);
            cal_busy  <= 1'b0;
            cal_done  <= 1'b1;
            state     <= DONE;
          end else if (code != '0) begin
            // Sweep stops at the first failing code.
            best      <= code - 1'b1;
            delay_sel <= lock_code(code - 1'b1);
            cal_busy  <= 1'b0;
            cal_done  <= 1'b1;
            state     <= DONE;
          end else begin
            delay_sel <= '0;
            cal_busy  <= 1'b0;
            cal_fail  <= 1'b1;
            state     <= FAIL;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_cal_ctrl.sv
// tb_delay_cal_ctrl -- self-checking bench for delay_cal_ctrl.
// The delay line is a timed behavioural model: each probe_out edge reaches
// probe_in after offset + code*step picoseconds plus a 125 ps capture setup
// window, so a delay of exactly one period (5 ns) counts as too late.
// Macro DELAY_CAL_MARGIN_EN must match the RTL build.
`timescale 1ns/1ps
module tb_delay_cal_ctrl;
  import delay_cal_pkg::*;

  localparam int SETTLE_CYC = 4;
  localparam int SAMPLES    = 8;
  localparam int TRIAL_CYC  = SETTLE_CYC + 2 * SAMPLES + 1;
  localparam int PERIOD_PS  = 5000;
  localparam int SETUP_PS   = 125;
  localparam int BUDGET     = 17 * TRIAL_CYC + 10;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       cal_start;
  logic       probe_out;
  logic       probe_in;
  logic [3:0] delay_sel;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  cal_state_e dbg_state;

  always #2.5 clk = ~clk;

  delay_cal_ctrl #(
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLES    (SAMPLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cal_start (cal_start),
    .probe_out (probe_out),
    .probe_in  (probe_in),
    .delay_sel (delay_sel),
    .cal_busy  (cal_busy),
    .cal_done  (cal_done),
    .cal_fail  (cal_fail),
    .dbg_state (dbg_state)
  );

  // ---------------- delay line model ----------------
  int line_offset_ps = 0;
  int line_step_ps   = 500;

  initial probe_in = 1'b0;

  always @(probe_out) begin
    automatic logic v = probe_out;
    automatic int   d = line_offset_ps + int'(delay_sel) * line_step_ps + SETUP_PS;
    fork
      begin
        #(real'(d) / 1000.0) probe_in = v;
      end
    join_none
  end

  // ---------------- scoreboard state ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [6:0] trace_q[$];   // per busy cycle: {cal_done, cal_fail, cal_busy, delay_sel}
  logic [6:0] exp_q[$];

  // Reference: walk the codes upward; a code passes when the probe edge
  // arrives strictly inside one clock period.
  function automatic void sweep_model(input int off, input int step,
                                      output bit exp_fail, output int exp_code,
                                      output int n_trials);
    exp_fail = 1'b0;
    exp_code = 0;
    n_trials = 16;
    for (int c = 0; c <= 15; c++) begin
      if (off + c * step + SETUP_PS >= PERIOD_PS) begin
        n_trials = c + 1;
        if (c == 0) exp_fail = 1'b1;
        else exp_code = c - 1;
        break;
      end
      exp_code = c;
    end
`ifdef DELAY_CAL_MARGIN_EN
    if (!exp_fail && exp_code > 0) exp_code = exp_code - 1;
`endif
  endfunction

  // ---------------- driver ----------------
  // Launches cal_start right after an edge; lat_o counts edges from that
  // launch edge until cal_done/cal_fail is seen (-1 on budget expiry).
  // At cycle poke_cyc either cal_start (poke_rst=0) or rst (poke_rst=1) is
  // pulsed; a reset poke ends the run right after its edge with lat_o = 0.
  task automatic run_sweep(input int poke_cyc, input bit poke_rst, output int lat_o);
    trace_q.delete();
    lat_o = -1;
    @(posedge clk); #1 cal_start = 1'b1;
    @(posedge clk); #1 cal_start = 1'b0;
    for (int n = 1; n <= BUDGET; n++) begin
      if (cal_done || cal_fail) begin
        lat_o = n;
        return;
      end
      trace_q.push_back({cal_done, cal_fail, cal_busy, delay_sel});
      if (n == poke_cyc) begin
        if (poke_rst) rst = 1'b1;
        else cal_start = 1'b1;
      end
      @(posedge clk); #1;
      rst       = 1'b0;
      cal_start = 1'b0;
      if (poke_rst && n == poke_cyc) begin
        lat_o = 0;
        return;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    cal_start = 1'b1;   // must lose against the simultaneous reset
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cal_busy, cal_done, cal_fail, probe_out, delay_sel} !== 8'h00) begin
      $display("FAIL reset_outputs: got busy/done/fail/probe/sel=%b, want 00000000",
               {cal_busy, cal_done, cal_fail, probe_out, delay_sel});
      miscompares++;
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      $display("FAIL reset_state: got %0d, want %0d", dbg_state, IDLE);
      miscompares++;
    end
    cal_start = 1'b0;
    rst = 1'b0;
    repeat (8) @(posedge clk);   // let the delay line settle
    #1;
    vectors++;
    if ({cal_busy, cal_done, cal_fail, delay_sel} !== 7'h00) begin
      $display("FAIL idle_hold: got busy/done/fail/sel=%b, want 0000000",
               {cal_busy, cal_done, cal_fail, delay_sel});
      miscompares++;
    end
  endtask

  task automatic test_sweep(input string name, input int off, input int step, input int poke_cyc);
    bit exp_fail;
    int exp_code;
    int n_trials;
    int lat;
    int exp_lat;
    line_offset_ps = off;
    line_step_ps   = step;
    sweep_model(off, step, exp_fail, exp_code, n_trials);
    exp_lat = n_trials * TRIAL_CYC + 1;
    run_sweep(poke_cyc, 1'b0, lat);

    vectors++;
    if (lat !== exp_lat) begin
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, exp_lat);
      miscompares++;
    end
    vectors++;
    if ({cal_done, cal_fail, cal_busy} !== {!exp_fail, exp_fail, 1'b0}) begin
      $display("FAIL %s flags: got done/fail/busy=%b, want %b", name,
               {cal_done, cal_fail, cal_busy}, {!exp_fail, exp_fail, 1'b0});
      miscompares++;
    end
    vectors++;
    if (delay_sel !== 4'(exp_code)) begin
      $display("FAIL %s delay_sel: got %0d, want %0d", name, delay_sel, exp_code);
      miscompares++;
    end

    // Busy trace: trial c occupies TRIAL_CYC consecutive cycles.
    exp_q.delete();
    for (int i = 0; i < n_trials * TRIAL_CYC; i++) exp_q.push_back({3'b001, 4'(i / TRIAL_CYC)});
    vectors++;
    if (trace_q.size() != exp_q.size()) begin
      $display("FAIL %s trace_len: got %0d, want %0d", name, trace_q.size(), exp_q.size());
      miscompares++;
    end else begin
      foreach (exp_q[i]) begin
        if (trace_q[i] !== exp_q[i]) begin
          $display("FAIL %s trace[%0d]: got done/fail/busy/sel=%b, want %b",
                   name, i, trace_q[i], exp_q[i]);
          miscompares++;
          break;
        end
      end
    end

    // Result must hold while idle in DONE/FAIL.
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({cal_done, cal_fail, delay_sel} !== {!exp_fail, exp_fail, 4'(exp_code)}) begin
      $display("FAIL %s hold: got done/fail/sel=%b, want %b", name,
               {cal_done, cal_fail, delay_sel}, {!exp_fail, exp_fail, 4'(exp_code)});
      miscompares++;
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    line_offset_ps = 0;
    line_step_ps   = 500;
    run_sweep(5 * TRIAL_CYC + 8, 1'b1, lat);
    vectors++;
    if (trace_q.size() == 0 || trace_q[trace_q.size()-1] !== 7'b0010101) begin
      $display("FAIL mid_reset_in_code5: got %b, want 0010101",
               (trace_q.size() == 0) ? 7'h7f : trace_q[trace_q.size()-1]);
      miscompares++;
    end
    vectors++;
    if ({cal_busy, cal_done, cal_fail, probe_out, delay_sel} !== 8'h00) begin
      $display("FAIL mid_reset_outputs: got busy/done/fail/probe/sel=%b, want 00000000",
               {cal_busy, cal_done, cal_fail, probe_out, delay_sel});
      miscompares++;
    end
    vectors++;
    if (dbg_state !== IDLE) begin
      $display("FAIL mid_reset_state: got %0d, want %0d", dbg_state, IDLE);
      miscompares++;
    end
    repeat (8) @(posedge clk);
    test_sweep("rerun_after_reset", 0, 500, 0);
  endtask

  task automatic test_random(input int iters);
    for (int k = 0; k < iters; k++) begin
      int off;
      int step;
      off  = 50 * int'($urandom_range(0, 100));
      step = 50 * int'($urandom_range(0, 12));
      test_sweep($sformatf("random%0d(off=%0d,step=%0d)", k, off, step), off, step, 0);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    cal_start = 1'b0;
    test_reset();
    test_sweep("nominal", 0, 500, 0);
    test_sweep("code0_fail", 6000, 500, 0);
    test_sweep("all_pass", 100, 0, 0);
    test_mid_reset();
    test_sweep("busy_start", 0, 500, 3 * TRIAL_CYC + 1);
    test_sweep("back_to_back", 0, 500, 0);
    test_random(6);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
